// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding a start/data/parity/stop serialiser
// with a per-frame latched baud divisor and frame format.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             tx_en,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             uart_tx,
  output logic             busy,
  output logic             tx_done,
  output logic [LVL_W-1:0] fifo_level,
  output logic             fifo_empty,
  output logic             fifo_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] BAUD_ONE = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push, pop;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             uart_tx_q, uart_tx_d;
  logic             tx_done_q, tx_done_d;
  logic             bit_end, can_start, load;
  logic [7:0]       fifo_head;

  assign wr_ready   = !full_q;
  assign push       = wr_valid && !full_q;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign bit_end    = (baud_cnt_q == div_q);
  assign can_start  = tx_en && !empty_q;
  assign uart_tx    = uart_tx_q;
  assign tx_done    = tx_done_q;
  assign busy       = (state_q != IDLE);
  assign fifo_level = level_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;

  // Storage array; contents are don't-care after reset since the pointers are cleared.
  always_ff @(posedge pclk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wr_data;
  end

  // Next pointer/level/flag values; pointers wrap naturally as the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    full_d   = (level_d == LVL_W'(FIFO_DEPTH));
    empty_d  = (level_d == '0);
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge pclk) begin
    if (prst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Frame sequencing; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_start) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          baud_cnt_d = '0;
          stop_cnt_d = 1'b0;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (stop_cnt_q == stop2_q) begin
            if (can_start) load = 1'b1;
            else           state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d    = START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      div_d      = baud_div;
      shift_d    = fifo_head;
      par_en_d   = parity_en;
      par_bit_d  = (^fifo_head) ^ parity_odd;
      stop2_d    = stop2;
      stop_cnt_d = 1'b0;
    end
    pop = load;
    case (state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = shift_d[0];
      PARITY:  uart_tx_d = par_bit_d;
      default: uart_tx_d = 1'b1;
    endcase
    tx_done_d = (state_d == STOP) && (stop_cnt_d == stop2_d) && (baud_cnt_d == div_d);
  end

  // Serialiser state and registered line/done outputs.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      uart_tx_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      uart_tx_q  <= uart_tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the expected line.
module tb_uart_tx_engine;

  localparam int DEPTH = 8;

  logic        pclk = 1'b0;
  logic        prst;
  logic [15:0] baudDiv;
  logic        txEn, parityEn, parityOdd, stop2;
  logic        wrValid;
  logic [7:0]  wrData;
  logic        wrReady, uartTx, busy, txDone, fifoEmpty, fifoFull;
  logic [3:0]  fifoLevel;

  int checks = 0;
  int failures = 0;

  // Model: bytes waiting in the FIFO, and the line value for each remaining cycle of the current frame.
  logic [7:0] modelData[$];
  logic       modelLine[$];

  uart_tx_engine #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .pclk(pclk), .prst(prst), .baud_div(baudDiv), .tx_en(txEn),
    .parity_en(parityEn), .parity_odd(parityOdd), .stop2(stop2),
    .wr_valid(wrValid), .wr_data(wrData), .wr_ready(wrReady),
    .uart_tx(uartTx), .busy(busy), .tx_done(txDone),
    .fifo_level(fifoLevel), .fifo_empty(fifoEmpty), .fifo_full(fifoFull)
  );

  // Free-running clock.
  always #5 pclk = ~pclk;

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expands one byte into its per-cycle line values using the current format inputs.
  function automatic void buildFrame(input logic [7:0] b);
    int n = int'(baudDiv) + 1;
    logic [15:0] bits[$];
    bits.push_back(16'd0);
    for (int i = 0; i < 8; i++) bits.push_back({15'd0, b[i]});
    if (parityEn) bits.push_back({15'd0, (^b) ^ parityOdd});
    bits.push_back(16'd1);
    if (stop2) bits.push_back(16'd1);
    foreach (bits[k]) for (int c = 0; c < n; c++) modelLine.push_back(bits[k][0]);
  endfunction

  // Advances the model by one clock edge using the inputs held across that edge.
  function automatic void modelEdge();
    logic fullBefore;
    logic junk;
    if (prst) begin
      modelData.delete();
      modelLine.delete();
      return;
    end
    fullBefore = (modelData.size() == DEPTH);
    if (modelLine.size() > 0) junk = modelLine.pop_front();
    if (modelLine.size() == 0 && txEn && modelData.size() > 0) buildFrame(modelData.pop_front());
    if (wrValid && !fullBefore) modelData.push_back(wrData);
  endfunction

  // Drives one cycle of write inputs, advances the model and compares every output.
  task automatic applyStimulus(input logic wv, input logic [7:0] wd);
    wrValid = wv;
    wrData  = wd;
    @(posedge pclk);
    modelEdge();
    @(negedge pclk);
    checkOutput("uart_tx",    uartTx,    modelLine.size() > 0 ? modelLine[0] : 1'b1);
    checkOutput("busy",       busy,      modelLine.size() > 0);
    checkOutput("tx_done",    txDone,    modelLine.size() == 1);
    checkOutput("fifo_level", fifoLevel, modelData.size());
    checkOutput("fifo_empty", fifoEmpty, modelData.size() == 0);
    checkOutput("fifo_full",  fifoFull,  modelData.size() == DEPTH);
    checkOutput("wr_ready",   wrReady,   modelData.size() != DEPTH);
    wrValid = 1'b0;
  endtask

  // Runs idle cycles until the model has nothing left to send, within a cycle budget.
  task automatic drain(input int maxCycles);
    int n = 0;
    while ((modelLine.size() > 0 || modelData.size() > 0) && n < maxCycles) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    checkOutput("drain_budget", n < maxCycles, 1'b1);
  endtask

  task automatic setFormat(input logic [15:0] d, input logic pe, input logic po, input logic s2);
    baudDiv = d; parityEn = pe; parityOdd = po; stop2 = s2;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int firstDone;
    int doneCnt;
    int doneAt[3];
    logic [11:0] wave;

    prst = 1'b1; txEn = 1'b1; wrValid = 1'b0; wrData = 8'h00;
    setFormat(16'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    prst = 1'b0;
    applyStimulus(1'b0, 8'h00);

    // Single byte 0x55, 4 cycles per bit, done pulse in cycle 40.
    applyStimulus(1'b1, 8'h55);
    firstDone = -1;
    for (int i = 1; i <= 45; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (txDone && firstDone < 0) firstDone = i;
    end
    checkOutput("single_done_cycle", firstDone, 40);
    drain(100);

    // Even parity, two stop bits, 1 cycle per bit, byte 0x07.
    setFormat(16'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h07);
    wave = '0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 8'h00);
      wave = {wave[10:0], uartTx};
    end
    checkOutput("parity_wave", wave, 12'b0111_0000_0111);
    drain(50);

    // Three back-to-back frames, 2 cycles per bit.
    setFormat(16'd1, 1'b0, 1'b0, 1'b0);
    doneCnt = 0;
    doneAt[0] = 0; doneAt[1] = 0; doneAt[2] = 0;
    applyStimulus(1'b1, 8'hA1);
    for (int i = 1; i <= 70; i++) begin
      if (i == 1)      applyStimulus(1'b1, 8'hB2);
      else if (i == 2) applyStimulus(1'b1, 8'hC3);
      else             applyStimulus(1'b0, 8'h00);
      if (txDone && doneCnt < 3) begin doneAt[doneCnt] = i; doneCnt++; end
    end
    checkOutput("b2b_done0", doneAt[0], 20);
    checkOutput("b2b_done1", doneAt[1], 40);
    checkOutput("b2b_done2", doneAt[2], 60);
    drain(50);

    // FIFO full: nine writes with transmission held off, then release.
    txEn = 1'b0;
    setFormat(16'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h10 + 8'(i));
    checkOutput("full_level", fifoLevel, 8);
    checkOutput("full_flag", fifoFull, 1'b1);
    checkOutput("full_ready", wrReady, 1'b0);
    txEn = 1'b1;
    drain(200);

    // Reset during data bit 3 with two bytes still queued.
    setFormat(16'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b1, 8'hE7);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00);
    prst = 1'b1;
    applyStimulus(1'b0, 8'h00);
    prst = 1'b0;
    checkOutput("rst_uart_tx", uartTx, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_level", fifoLevel, 0);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 8'h00);

    // tx_en dropped during the start bit with two bytes queued.
    applyStimulus(1'b1, 8'h81);
    applyStimulus(1'b1, 8'h42);
    applyStimulus(1'b1, 8'h24);
    txEn = 1'b0;
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 8'h00);
    checkOutput("hold_level", fifoLevel, 2);
    checkOutput("hold_busy", busy, 1'b0);
    txEn = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("resume_start", uartTx, 1'b0);
    drain(200);

    // Random traffic, format changes (including mid-frame), tx_en toggles and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)
        setFormat(16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 49) == 0) txEn = ~txEn;
      prst = ($urandom_range(0, 399) == 0);
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
    end
    prst = 1'b0;
    txEn = 1'b1;
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit datapath for the UART peripheral. Sits directly downstream of the APB register block: the register block drives baud divisor, frame-format bits and byte writes into this engine. The engine buffers bytes in a small FIFO and serialises them onto `uart_tx` as 8-bit asynchronous frames (start bit, LSB-first data, optional parity, 1 or 2 stop bits). Single clock domain (`pclk`); the baud rate is derived by an internal divider.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, ≥2.
- `DIV_W`, 16: baud divisor width.
- `LVL_W`, $clog2(FIFO_DEPTH)+1: width of the level output.

- `pclk` in 1: sole clock; all state changes on its rising edge.
- `prst` in 1: reset. Synchronous, active-high.
- `baud_div` in DIV_W: bit period = `baud_div`+1 `pclk` cycles.
- `tx_en` in 1: permits new frames to start.
- `parity_en` in 1: insert a parity bit after the data bits.
- `parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `stop2` in 1: 1 = two stop bits, 0 = one stop bit.
- `wr_valid` in 1: byte write request from the register block.
- `wr_data` in 8: byte to transmit.
- `wr_ready` out 1: equals `!fifo_full`.
- `uart_tx` out 1: serial line; idles high.
- `busy` out 1: high while a frame is in progress (any state except IDLE).
- `tx_done` out 1: one-cycle pulse in the last cycle of the final stop bit.
- `fifo_level` out LVL_W: number of occupied FIFO entries.
- `fifo_empty`, `fifo_full` out 1: FIFO status flags.

## Operation
- **FIFO.**
  - A push occurs when `wr_valid && wr_ready`.
  - A pop occurs when the FSM leaves IDLE or STOP to start a frame.
  - Push and pop may happen in the same cycle; the level is then unchanged.
  - When full, `wr_ready`=0 and writes are dropped, even if a pop happens in the same cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Frame parameters.** `baud_div`, `parity_en`, `parity_odd` and `stop2` are latched when a frame starts. Changing them mid-frame has no effect until the next frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `tx_en` && !`fifo_empty`. The byte is popped into the shift register and the bit counter is cleared.
  - START: `uart_tx`=0 for one bit period, then → DATA.
  - DATA: `uart_tx` = shift[0]. Shift right at the end of each bit. After 8 bits → PARITY if parity is enabled, else → STOP.
  - PARITY: `uart_tx` = XOR of the data bits XOR `parity_odd`. Lasts one bit period, then → STOP.
  - STOP: `uart_tx`=1 for 1 or 2 bit periods.
    - At the end of the final stop bit, `tx_done` pulses.
    - If `tx_en` && !`fifo_empty`: pop and → START (no idle gap between frames).
    - Otherwise → IDLE.
- **Baud counter.**
  - Counts from 0 up to the latched divisor; the terminal count marks the end of a bit.
  - It is reset to 0 on every state entry.
  - `baud_div`=0 gives 1 cycle per bit.
- **`tx_en` deasserted mid-frame:** the current frame completes. No new frame starts.
- **`busy`** = (state != IDLE).

## Timing
- **Reset values:** `uart_tx`=1, `busy`=0, `tx_done`=0, `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0, `wr_ready`=1. FSM in IDLE, pointers at 0.
- **Reset mid-frame:** `uart_tx` returns to 1 at the reset edge. The FIFO is flushed and any partial frame is discarded.
- **Start latency:** a write accepted at edge E into an empty FIFO, with the engine idle and `tx_en`=1:
  - the start bit begins at edge E+1 (`uart_tx`=0 after E+1);
  - `busy` rises at E+1.
- **Frame length:** (1 + 8 + `parity_en` + 1 + `stop2`) × (`baud_div`+1) cycles.
- **Back-to-back frames:** the next start bit begins on the edge immediately after the last stop-bit cycle.
- **`tx_done`:** asserted in exactly one cycle per frame, registered, coincident with the last stop-bit cycle.
- **Flag timing:**
  - `fifo_level` and the flags update on the edge following a push or pop.
  - `wr_ready` is combinational from the registered full flag.

## Test plan
- **Single byte:** `baud_div`=3, no parity, 1 stop, write 0x55.
  - `uart_tx` sequence in 4-cycle bits: 0,1,0,1,0,1,0,1,0,1 (40 cycles).
  - `tx_done` pulses in cycle 40; `busy` falls after it.
- **Even parity:** `parity_en`=1, `parity_odd`=0, `stop2`=1, `baud_div`=0, write 0x07.
  - Parity bit = 1.
  - Frame is 12 cycles: 0,1,1,1,0,0,0,0,0,1,1,1.
- **Back-to-back:** write 0xA1, 0xB2, 0xC3 in consecutive cycles with `baud_div`=1.
  - Three contiguous 20-cycle frames with no idle cycle between them.
  - `tx_done` pulses at cycles 20, 40, 60.
- **FIFO full:** `tx_en`=0, write 9 bytes.
  - After 8 writes: `fifo_full`=1, `wr_ready`=0, `fifo_level`=8; the 9th byte is dropped.
  - Then set `tx_en`=1: exactly 8 frames are sent, in order.
- **Reset mid-frame:** assert `prst` during DATA bit 3 with 2 bytes still queued.
  - Next cycle: `uart_tx`=1, `busy`=0, `fifo_level`=0; no further frames.
- **`tx_en` drop:** deassert `tx_en` during the START bit with 2 bytes queued.
  - The current frame completes; no next frame starts and `fifo_level` stays 2.
  - Reassert `tx_en`: the next start bit begins 1 cycle later.
